// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared encodings for the execute-stage ALU block
package alu_exec_unit_pkg;

    localparam logic [3:0] ALUOP_ADDU  = 4'b0000;
    localparam logic [3:0] ALUOP_SUBU  = 4'b0001;
    localparam logic [3:0] ALUOP_FUNCT = 4'b0010;
    localparam logic [3:0] ALUOP_AND   = 4'b0011;
    localparam logic [3:0] ALUOP_OR    = 4'b0100;
    localparam logic [3:0] ALUOP_XOR   = 4'b0101;
    localparam logic [3:0] ALUOP_LUI   = 4'b0110;
    localparam logic [3:0] ALUOP_SLT   = 4'b0111;
    localparam logic [3:0] ALUOP_SLTU  = 4'b1000;
    localparam logic [3:0] ALUOP_ADD   = 4'b1001;

    typedef enum logic [4:0] {
        ALU_ADDU  = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUBU  = 5'd2,
        ALU_SUB   = 5'd3,
        ALU_AND   = 5'd4,
        ALU_OR    = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_NOR   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_SLL   = 5'd10,
        ALU_SRL   = 5'd11,
        ALU_SRA   = 5'd12,
        ALU_LUI   = 5'd13,
        ALU_MULT  = 5'd14,
        ALU_MULTU = 5'd15,
        ALU_MFHI  = 5'd16,
        ALU_MFLO  = 5'd17
    } alu_ctrl_e;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - ALUOp/funct to ALU operation decode
module alu_ctrl_dec
    import alu_exec_unit_pkg::*;
(
    input  logic [3:0] alu_op,
    input  logic [5:0] funct,
    output logic [4:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADDU;
        case (alu_op)
            ALUOP_ADDU: alu_ctrl = ALU_ADDU;
            ALUOP_SUBU: alu_ctrl = ALU_SUBU;
            ALUOP_AND:  alu_ctrl = ALU_AND;
            ALUOP_OR:   alu_ctrl = ALU_OR;
            ALUOP_XOR:  alu_ctrl = ALU_XOR;
            ALUOP_LUI:  alu_ctrl = ALU_LUI;
            ALUOP_SLT:  alu_ctrl = ALU_SLT;
            ALUOP_SLTU: alu_ctrl = ALU_SLTU;
            ALUOP_ADD:  alu_ctrl = ALU_ADD;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100001: alu_ctrl = ALU_ADDU;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100011: alu_ctrl = ALU_SUBU;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b100110: alu_ctrl = ALU_XOR;
                    6'b100111: alu_ctrl = ALU_NOR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    6'b101011: alu_ctrl = ALU_SLTU;
                    // Variable shifts share the constant-shift code; the
                    // operand mux upstream already selects rs or shamt.
                    6'b000000, 6'b000100: alu_ctrl = ALU_SLL;
                    6'b000010, 6'b000110: alu_ctrl = ALU_SRL;
                    6'b000011, 6'b000111: alu_ctrl = ALU_SRA;
                    6'b011000: alu_ctrl = ALU_MULT;
                    6'b011001: alu_ctrl = ALU_MULTU;
                    6'b010000: alu_ctrl = ALU_MFHI;
                    6'b010010: alu_ctrl = ALU_MFLO;
                    default:   alu_ctrl = ALU_ADDU;
                endcase
            end
            default: alu_ctrl = ALU_ADDU;
        endcase
    end

endmodule

// File: rtl/mem_be_dec.sv
// rtl/mem_be_dec.sv - byte-lane enable and unsigned-load decode for the MEM stage
module mem_be_dec
    import alu_exec_unit_pkg::*;
(
    input  logic [5:0] mem_op,
    input  logic [1:0] mem_addr_lo,
    output logic [3:0] be,
    output logic       u
);

    always_comb begin
        be = 4'b0000;
        u  = 1'b0;
        case (mem_op)
            OP_LW, OP_SW:
                be = 4'b1111;
            OP_LH, OP_LHU, OP_SH: begin
                be = mem_addr_lo[1] ? 4'b1100 : 4'b0011;
                u  = (mem_op == OP_LHU);
            end
            OP_LB, OP_LBU, OP_SB: begin
                be = 4'b0001 << mem_addr_lo;
                u  = (mem_op == OP_LBU);
            end
            default: begin
                be = 4'b0000;
                u  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with 64-bit product path and HI/LO registers
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_en,
    input  logic [5:0]  mem_op,
    input  logic [1:0]  mem_addr_lo,
    output logic [4:0]  alu_ctrl,
    output logic [63:0] result,
    output logic        zero,
    output logic        sign,
    output logic        ov,
    output logic [3:0]  be,
    output logic        u
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] sum, diff, sra_res;
    logic [63:0] prod_s, prod_u;
    logic        is_mul;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

    mem_be_dec u_mem_be_dec (
        .mem_op      (mem_op),
        .mem_addr_lo (mem_addr_lo),
        .be          (be),
        .u           (u)
    );

    assign sum     = a + b;
    assign diff    = a - b;
    assign sra_res = $signed(b) >>> a[4:0];
    // Operands are widened explicitly so the low 64 bits of each product are exact.
    assign prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u  = {32'h0, a} * {32'h0, b};

    always_comb begin
        result = 64'h0;
        ov     = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                result = {32'h0, sum};
                ov     = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result = {32'h0, diff};
                ov     = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_SUBU:  result = {32'h0, diff};
            ALU_AND:   result = {32'h0, a & b};
            ALU_OR:    result = {32'h0, a | b};
            ALU_XOR:   result = {32'h0, a ^ b};
            ALU_NOR:   result = {32'h0, ~(a | b)};
            ALU_SLT:   result = {63'h0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {63'h0, a < b};
            ALU_SLL:   result = {32'h0, b << a[4:0]};
            ALU_SRL:   result = {32'h0, b >> a[4:0]};
            ALU_SRA:   result = {32'h0, sra_res};
            ALU_LUI:   result = {32'h0, b[15:0], 16'h0};
            ALU_MULT:  result = prod_s;
            ALU_MULTU: result = prod_u;
            ALU_MFHI:  result = {32'h0, hi_q};
            ALU_MFLO:  result = {32'h0, lo_q};
            default:   result = {32'h0, sum};
        endcase
    end

    assign zero   = (result[31:0] == 32'h0);
    assign sign   = result[31];
    assign is_mul = (alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_MULTU);

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hilo_en && is_mul) begin
            hi_d = result[63:32];
            lo_d = result[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic        hilo_en;
    logic [5:0]  mem_op;
    logic [1:0]  mem_addr_lo;
    logic [4:0]  alu_ctrl;
    logic [63:0] result;
    logic        zero, sign, ov;
    logic [3:0]  be;
    logic        u;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    alu_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .alu_op      (alu_op),
        .funct       (funct),
        .a           (a),
        .b           (b),
        .hilo_en     (hilo_en),
        .mem_op      (mem_op),
        .mem_addr_lo (mem_addr_lo),
        .alu_ctrl    (alu_ctrl),
        .result      (result),
        .zero        (zero),
        .sign        (sign),
        .ov          (ov),
        .be          (be),
        .u           (u)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_ctrl(input logic [3:0] op, input logic [5:0] f);
        case (op)
            4'd0: return 0;
            4'd1: return 2;
            4'd3: return 4;
            4'd4: return 5;
            4'd5: return 6;
            4'd6: return 13;
            4'd7: return 8;
            4'd8: return 9;
            4'd9: return 1;
            4'd2: begin
                case (f)
                    6'o40: return 1;
                    6'o41: return 0;
                    6'o42: return 3;
                    6'o43: return 2;
                    6'o44: return 4;
                    6'o45: return 5;
                    6'o46: return 6;
                    6'o47: return 7;
                    6'o52: return 8;
                    6'o53: return 9;
                    6'o00, 6'o04: return 10;
                    6'o02, 6'o06: return 11;
                    6'o03, 6'o07: return 12;
                    6'o30: return 14;
                    6'o31: return 15;
                    6'o20: return 16;
                    6'o22: return 17;
                    default: return 0;
                endcase
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_result(input int c, input logic [31:0] x, input logic [31:0] y,
                                               input logic [31:0] hi, input logic [31:0] lo);
        int          sx, sy;
        longint      sp;
        longint unsigned up;
        logic [31:0] r;
        sx = x;
        sy = y;
        case (c)
            2, 3:  r = x - y;
            4:     r = x & y;
            5:     r = x | y;
            6:     r = x ^ y;
            7:     r = ~(x | y);
            8:     r = (sx < sy) ? 32'd1 : 32'd0;
            9:     r = (x < y) ? 32'd1 : 32'd0;
            10:    r = y << x[4:0];
            11:    r = y >> x[4:0];
            12:    r = sy >>> x[4:0];
            13:    r = {y[15:0], 16'h0};
            14: begin
                sp = longint'(sx) * longint'(sy);
                return sp;
            end
            15: begin
                up = longint'({32'h0, x}) * longint'({32'h0, y});
                return up;
            end
            16:    r = hi;
            17:    r = lo;
            default: r = x + y;
        endcase
        return {32'h0, r};
    endfunction

    function automatic logic ref_ov(input int c, input logic [31:0] x, input logic [31:0] y);
        int     sx, sy;
        longint s;
        sx = x;
        sy = y;
        if (c == 1)      s = longint'(sx) + longint'(sy);
        else if (c == 3) s = longint'(sx) - longint'(sy);
        else             return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [4:0] ref_be(input logic [5:0] op, input logic [1:0] ad);
        case (op)
            6'b100011, 6'b101011: return {1'b0, 4'b1111};
            6'b100001, 6'b101001: return {1'b0, ad[1] ? 4'b1100 : 4'b0011};
            6'b100101:            return {1'b1, ad[1] ? 4'b1100 : 4'b0011};
            6'b100000, 6'b101000: return {1'b0, 4'(1 << ad)};
            6'b100100:            return {1'b1, 4'(1 << ad)};
            default:              return 5'b0;
        endcase
    endfunction

    task automatic run(input string tag, input logic [3:0] op, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y, input logic en,
                       input logic [5:0] mop, input logic [1:0] madr);
        int          c;
        logic [63:0] er;
        logic [4:0]  eb;
        @(negedge clk);
        alu_op = op; funct = f; a = x; b = y; hilo_en = en;
        mem_op = mop; mem_addr_lo = madr;
        #2;
        c  = ref_ctrl(op, f);
        er = ref_result(c, x, y, m_hi, m_lo);
        eb = ref_be(mop, madr);
        check({tag, ".ctrl"},   64'(alu_ctrl), 64'(c));
        check({tag, ".result"}, result, er);
        check({tag, ".zero"},   64'(zero), 64'(er[31:0] == 32'h0));
        check({tag, ".sign"},   64'(sign), 64'(er[31]));
        check({tag, ".ov"},     64'(ov), 64'(ref_ov(c, x, y)));
        check({tag, ".be"},     64'(be), 64'(eb[3:0]));
        check({tag, ".u"},      64'(u), 64'(eb[4]));
        if (en && reset && (c == 14 || c == 15)) begin
            m_hi = er[63:32];
            m_lo = er[31:0];
        end
    endtask

    logic [5:0] funct_pool [0:18] = '{6'o40, 6'o41, 6'o42, 6'o43, 6'o44, 6'o45, 6'o46, 6'o47,
                                      6'o52, 6'o53, 6'o00, 6'o04, 6'o02, 6'o06, 6'o03, 6'o07,
                                      6'o30, 6'o31, 6'o20};
    logic [5:0] mop_pool [0:8] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                   6'b101000, 6'b101001, 6'b101011, 6'b000100};

    initial begin
        reset = 1'b0;
        alu_op = 4'd2; funct = 6'o20; a = '0; b = '0; hilo_en = 1'b0;
        mem_op = 6'b000100; mem_addr_lo = 2'd0;
        #2;
        check("reset.mfhi", result, 64'h0);
        run("reset.mflo", 4'd2, 6'o22, 32'h0, 32'h0, 1'b0, 6'b000100, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        run("add_ov",   4'd9, 6'o00, 32'h7FFFFFFF, 32'h1, 1'b0, 6'b000000, 2'd0);
        check("add_ov.direct", {62'h0, ov, sign}, 64'h3);
        run("addu_wrap", 4'd0, 6'o00, 32'h7FFFFFFF, 32'h1, 1'b0, 6'b000000, 2'd0);
        run("sra",      4'd2, 6'o03, 32'h4, 32'hF0000000, 1'b0, 6'b000000, 2'd0);
        check("sra.direct", result, 64'hFF000000);
        run("slt",      4'd7, 6'o00, 32'hFFFFFFFF, 32'h1, 1'b0, 6'b000000, 2'd0);
        run("sltu",     4'd8, 6'o00, 32'hFFFFFFFF, 32'h1, 1'b0, 6'b000000, 2'd0);
        run("subu_z",   4'd1, 6'o00, 32'h5, 32'h5, 1'b0, 6'b000000, 2'd0);
        run("mult",     4'd2, 6'o30, 32'hFFFFFFFE, 32'h3, 1'b1, 6'b000000, 2'd0);
        check("mult.direct", result, 64'hFFFFFFFF_FFFFFFFA);
        run("mfhi",     4'd2, 6'o20, 32'h0, 32'h0, 1'b0, 6'b000000, 2'd0);
        check("mfhi.direct", result, 64'hFFFFFFFF);
        run("mflo",     4'd2, 6'o22, 32'h0, 32'h0, 1'b0, 6'b000000, 2'd0);
        check("mflo.direct", result, 64'hFFFFFFFA);
        run("mult_off", 4'd2, 6'o31, 32'h12345678, 32'h9, 1'b0, 6'b000000, 2'd0);
        run("mflo_hold", 4'd2, 6'o22, 32'h0, 32'h0, 1'b0, 6'b000000, 2'd0);
        run("sb2",      4'd0, 6'o00, 32'h0, 32'h0, 1'b0, 6'b101000, 2'd2);
        run("lhu3",     4'd0, 6'o00, 32'h0, 32'h0, 1'b0, 6'b100101, 2'd3);
        run("lw1",      4'd0, 6'o00, 32'h0, 32'h0, 1'b0, 6'b100011, 2'd1);
        run("beq",      4'd0, 6'o00, 32'h0, 32'h0, 1'b0, 6'b000100, 2'd1);
        run("lui",      4'd6, 6'o00, 32'h0, 32'h0000ABCD, 1'b0, 6'b000000, 2'd0);
        run("bad_funct", 4'd2, 6'o77, 32'h1, 32'h2, 1'b0, 6'b000000, 2'd0);
        run("sub_ov",   4'd2, 6'o42, 32'h80000000, 32'h1, 1'b0, 6'b000000, 2'd0);
        run("multu",    4'd2, 6'o31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 6'b000000, 2'd0);
        run("mfhi_u",   4'd2, 6'o20, 32'h0, 32'h0, 1'b0, 6'b000000, 2'd0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0]  rop;
            logic [5:0]  rf, rm;
            logic [31:0] ra, rb;
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rop = 4'd2;
            rf = ($urandom_range(0, 5) == 0) ? 6'($urandom) : funct_pool[$urandom_range(0, 18)];
            if ($urandom_range(0, 7) == 0) rf = ($urandom_range(0, 1) == 0) ? 6'o22 : 6'o20;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 4) == 0) ra = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'h7FFFFFFF};
            rm = ($urandom_range(0, 4) == 0) ? 6'($urandom) : mop_pool[$urandom_range(0, 8)];
            run($sformatf("rnd%0d", i), rop, rf, ra, rb, 1'($urandom), rm, 2'($urandom));
        end

        run("pre_rst_mult", 4'd2, 6'o31, 32'h3, 32'h5, 1'b1, 6'b000000, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        #1;
        alu_op = 4'd2; funct = 6'o22;
        #1;
        check("async_rst.mflo", result, 64'h0);
        run("rst_mult", 4'd2, 6'o30, 32'h7, 32'h9, 1'b1, 6'b000000, 2'd0);
        run("rst_mflo", 4'd2, 6'o22, 32'h0, 32'h0, 1'b0, 6'b000000, 2'd0);
        run("rst_mfhi", 4'd2, 6'o20, 32'h0, 32'h0, 1'b0, 6'b000000, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        run("post_rst_mflo", 4'd2, 6'o22, 32'h0, 32'h0, 1'b0, 6'b000000, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
